// File: rtl/ntt_load_ctrl_if.sv
// ntt_load_ctrl_if: groups the streaming, TF-table, coefficient-memory and
// NTT-control signals of ntt_load_ctrl.
//   master : the controller side (drives s_ready, tf_*, mem_* strobes/buses,
//            ntt_start, m_valid/m_data, busy, err)
//   slave  : the environment side (host stream, memories, NTT core, sink)
interface ntt_load_ctrl_if #(
    parameter int unsigned DW      = 24,
    parameter int unsigned BN      = 16,
    parameter int unsigned MA      = 16,
    parameter int unsigned TF_ROWS = 8,
    parameter int unsigned TF_COLS = 15
);
    localparam int unsigned RW = $clog2(TF_ROWS);
    localparam int unsigned CW = $clog2(TF_COLS);
    localparam int unsigned BW = $clog2(BN);
    localparam int unsigned AW = $clog2(MA);

    logic          start;
    logic [DW-1:0] modulus;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          tf_we;
    logic          tf_const;
    logic [RW-1:0] tf_row;
    logic [CW-1:0] tf_col;
    logic [DW-1:0] tf_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [BW-1:0] mem_bank;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ntt_start;
    logic          ntt_done;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          err;

    modport master (
        input  start, modulus, s_valid, s_data, mem_rdata, ntt_done, m_ready,
        output s_ready, tf_we, tf_const, tf_row, tf_col, tf_wdata,
               mem_we, mem_re, mem_bank, mem_addr, mem_wdata,
               ntt_start, m_valid, m_data, busy, err
    );

    modport slave (
        output start, modulus, s_valid, s_data, mem_rdata, ntt_done, m_ready,
        input  s_ready, tf_we, tf_const, tf_row, tf_col, tf_wdata,
               mem_we, mem_re, mem_bank, mem_addr, mem_wdata,
               ntt_start, m_valid, m_data, busy, err
    );
endinterface

// File: rtl/ntt_load_ctrl.sv
// ntt_load_ctrl: streams TF base table, TF constant table and coefficients
// into the NTT top, kicks the NTT, waits for done and streams the banks out
// through a 2-entry output FIFO.
// Ports: clk, rst (async active-low), bus (ntt_load_ctrl_if.master).
// Optional: NTT_LOAD_RANGE_CHECK_EN enables the sticky coefficient range
// error (s_data >= modulus during LD_DATA); otherwise err is tied 0.
module ntt_load_ctrl #(
    parameter int unsigned DW      = 24,
    parameter int unsigned BN      = 16,
    parameter int unsigned MA      = 16,
    parameter int unsigned TF_ROWS = 8,
    parameter int unsigned TF_COLS = 15
) (
    input  logic             clk,
    input  logic             rst,
    ntt_load_ctrl_if.master  bus
);
    localparam int unsigned RW = $clog2(TF_ROWS);
    localparam int unsigned CW = $clog2(TF_COLS);
    localparam int unsigned BW = $clog2(BN);
    localparam int unsigned AW = $clog2(MA);
    localparam int unsigned NW = $clog2(BN * MA);

    typedef enum logic [2:0] {
        IDLE, LD_TFB, LD_TFC, LD_DATA, KICK, RUN, UNLOAD
    } state_t;

    state_t                 state_q, state_d;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic [BW-1:0]          bank_q;
    logic [AW-1:0]          addr_q;
    logic [NW-1:0]          out_q;
    logic                   rd_all_q;
    logic                   infl_q;
    logic [1:0][DW-1:0]     fifo_q;
    logic                   wp_q, rp_q;
    logic [1:0]             occ_q;
    logic                   err_q;

    logic ld_phase, acc, pop, rd_issue;
    logic tfb_last, tfc_last, col_last, bank_last, data_last, out_last;

    assign ld_phase  = (state_q == LD_TFB) || (state_q == LD_TFC) || (state_q == LD_DATA);
    assign acc       = ld_phase && bus.s_valid;
    assign pop       = (occ_q != 2'd0) && bus.m_ready;
    assign col_last  = (col_q == CW'(TF_COLS - 1));
    assign tfb_last  = (row_q == RW'(TF_ROWS - 1)) && col_last;
    assign tfc_last  = (col_q == CW'(TF_COLS - 2));
    assign bank_last = (bank_q == BW'(BN - 1));
    assign data_last = bank_last && (addr_q == AW'(MA - 1));
    assign out_last  = (out_q == NW'(BN * MA - 1));

    // A read may issue if the word popped this cycle frees the slot it needs.
    assign rd_issue = (state_q == UNLOAD) && !rd_all_q &&
                      ((3'(occ_q) + 3'(infl_q)) < (3'd2 + 3'(pop)));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start)          state_d = LD_TFB;
            LD_TFB:  if (acc && tfb_last)    state_d = LD_TFC;
            LD_TFC:  if (acc && tfc_last)    state_d = LD_DATA;
            LD_DATA: if (acc && data_last)   state_d = KICK;
            KICK:                            state_d = RUN;
            RUN:     if (bus.ntt_done)       state_d = UNLOAD;
            UNLOAD:  if (pop && out_last)    state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Outputs: write strobes follow the handshake, indices come from counters
    always_comb begin
        bus.s_ready   = ld_phase;
        bus.tf_we     = 1'b0;
        bus.tf_const  = (state_q == LD_TFC);
        bus.tf_row    = row_q;
        bus.tf_col    = col_q;
        bus.tf_wdata  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = rd_issue;
        bus.mem_bank  = bank_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = '0;
        bus.ntt_start = (state_q == KICK);
        bus.m_valid   = (occ_q != 2'd0);
        bus.m_data    = fifo_q[rp_q];
        bus.busy      = (state_q != IDLE);
        bus.err       = err_q;
        if ((state_q == LD_TFB || state_q == LD_TFC) && bus.s_valid) begin
            bus.tf_we    = 1'b1;
            bus.tf_wdata = bus.s_data;
        end
        if (state_q == LD_DATA && bus.s_valid) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.s_data;
        end
    end

    // Index counters, read tracking and the 2-entry output FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q    <= '0;
            col_q    <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            out_q    <= '0;
            rd_all_q <= 1'b0;
            infl_q   <= 1'b0;
            fifo_q   <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (acc && state_q == LD_TFB) begin
                col_q <= col_last ? '0 : col_q + CW'(1);
                if (col_last) row_q <= tfb_last ? '0 : row_q + RW'(1);
            end
            if (acc && state_q == LD_TFC) begin
                col_q <= tfc_last ? '0 : col_q + CW'(1);
            end
            // Writes and reads walk bank-fastest, then address.
            if ((acc && state_q == LD_DATA) || rd_issue) begin
                bank_q <= bank_last ? '0 : bank_q + BW'(1);
                if (bank_last) addr_q <= data_last ? '0 : addr_q + AW'(1);
            end
            if (rd_issue && data_last) rd_all_q <= 1'b1;
            infl_q <= rd_issue;
            if (infl_q) begin
                fifo_q[wp_q] <= bus.mem_rdata;
                wp_q         <= ~wp_q;
            end
            if (pop) begin
                rp_q  <= ~rp_q;
                out_q <= out_last ? '0 : out_q + NW'(1);
                if (out_last) rd_all_q <= 1'b0;
            end
            occ_q <= occ_q + 2'(infl_q) - 2'(pop);
        end
    end

`ifdef NTT_LOAD_RANGE_CHECK_EN
    // Sticky out-of-range flag; the offending word is still written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         err_q <= 1'b0;
        else if (state_q == IDLE && bus.start)            err_q <= 1'b0;
        else if (acc && state_q == LD_DATA &&
                 bus.s_data >= bus.modulus)               err_q <= 1'b1;
    end
`else
    // modulus only feeds the range comparator.
    logic unused_modulus;
    assign unused_modulus = ^bus.modulus;
    assign err_q          = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_load_ctrl.sv
// tb_ntt_load_ctrl: scoreboard bench for ntt_load_ctrl. Stimulus pushes the
// expected TF/memory writes and unload words into queues; a negedge monitor
// pops and compares whenever the DUT strobes a write or hands out a word.
module tb_ntt_load_ctrl;
    localparam int unsigned DW = 24, BN = 16, MA = 16, TF_ROWS = 8, TF_COLS = 15;

    typedef struct {
        int kind;   // 0 TF base, 1 TF const, 2 coefficient memory
        int i1;     // tf_row or mem_bank
        int i2;     // tf_col or mem_addr
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntt_load_ctrl_if #(.DW(DW), .BN(BN), .MA(MA), .TF_ROWS(TF_ROWS), .TF_COLS(TF_COLS)) bus ();

    ntt_load_ctrl #(.DW(DW), .BN(BN), .MA(MA), .TF_ROWS(TF_ROWS), .TF_COLS(TF_COLS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Coefficient memory: returns addr*16+bank one cycle after mem_re.
    always @(posedge clk)
        bus.mem_rdata <= bus.mem_re ? DW'({bus.mem_addr, bus.mem_bank}) : '0;

    wr_t wq[$];
    int  oq[$];
    int  vectors = 0, errors = 0;
    int  cyc = 0, starts = 0, issued = 0, acc_cnt = 0;
    int  first_acc = -1, last_acc = -1;
    bit  done_given = 1'b0;

`ifdef NTT_LOAD_RANGE_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic wr_t mk(input int k, input int a, input int b, input int d);
        wr_t w;
        w.kind = k; w.i1 = a; w.i2 = b; w.data = d;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, {bus.s_ready, bus.tf_we, bus.tf_const, bus.mem_we, bus.mem_re,
                               bus.ntt_start, bus.m_valid, bus.busy, bus.err}, 0);
        check({name, "_bus"}, (|bus.tf_row) | (|bus.tf_col) | (|bus.tf_wdata) | (|bus.mem_bank) |
                              (|bus.mem_addr) | (|bus.mem_wdata) | (|bus.m_data), 0);
    endtask

    // Present one word, optionally with start/ntt_done, until it is accepted.
    task automatic send(input int data, input wr_t e, input bit do_start, input bit do_done);
        int t;
        bus.s_valid  = 1'b1;
        bus.s_data   = DW'(data);
        bus.start    = do_start;
        bus.ntt_done = do_done;
        wq.push_back(e);
        t = 0;
        while (!bus.s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("s_ready_timeout", bus.s_ready, 1);
        tick();
        bus.s_valid  = 1'b0;
        bus.start    = 1'b0;
        bus.ntt_done = 1'b0;
    endtask

    // One job. toggle: s_valid gaps in LD_DATA; rst_at: data word index at
    // which reset hits (-1 none); low: m_ready low cycles; tput: timing checks.
    task automatic run_job(input bit toggle, input int rst_at, input int low, input bit tput);
        int d, t, k;
        wq.delete(); oq.delete();
        starts = 0; issued = 0; acc_cnt = 0; first_acc = -1; last_acc = -1;
        done_given = 1'b0;
        bus.m_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("err_clear_on_start", bus.err, 0);
        for (int n = 0; n < 120; n++) send(n, mk(0, n / 15, n % 15, n), 1'b0, 1'b0);
        for (int n = 0; n < 14; n++) send(120 + n, mk(1, 0, n, 120 + n), n == 5, 1'b0);
        for (int n = 0; n < 256; n++) begin
            if (n == rst_at) begin
                bus.s_valid = 1'b1;
                bus.s_data  = DW'(n);
                #1 rst = 1'b0;
                #1 check_zero("rst_mid");
                bus.s_valid = 1'b0;
                repeat (3) tick();
                rst = 1'b1;
                wq.delete();
                tick();
                return;
            end
            d = n;
`ifdef NTT_LOAD_RANGE_CHECK_EN
            if (n == 40) d = 65537;
`endif
            send(d, mk(2, n % 16, n / 16, d), 1'b0, n == 50);
            if (n == 40) check("err_after_word40", bus.err, ERR_EXP);
            if (toggle) tick();
        end
        repeat (5) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("one_ntt_start_run", starts, 1);
        check("busy_in_run", bus.busy, 1);
        for (int n = 0; n < 256; n++) oq.push_back(n);
        bus.m_ready  = (low == 0);
        done_given   = 1'b1;
        bus.ntt_done = 1'b1;
        tick();
        bus.ntt_done = 1'b0;
        if (tput) begin
            k = 0;
            forever begin
                @(negedge clk);
                if (bus.m_valid || k >= 10) break;
                k++;
            end
            check("unload_latency", k, 2);
        end
        if (low != 0) begin
            repeat (low) tick();
            bus.m_ready = 1'b1;
        end
        t = 0;
        while (bus.busy && t < 2000) begin
            tick();
            t++;
        end
        check("unload_finished", bus.busy, 0);
        check("out_queue_empty", oq.size(), 0);
        check("wr_queue_empty", wq.size(), 0);
        check("one_ntt_start_end", starts, 1);
        if (tput) check("unload_throughput", last_acc - first_acc, 255);
    endtask

    // Monitor: compares every write strobe and every handed-out word.
    initial begin : monitor
        wr_t a, e;
        int exp_d;
        logic stall_prev;
        logic [DW-1:0] prev_data;
        stall_prev = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.tf_we || bus.mem_we) begin
                a.kind = bus.mem_we ? 2 : (bus.tf_const ? 1 : 0);
                a.i1   = bus.mem_we ? int'(bus.mem_bank) : int'(bus.tf_row);
                a.i2   = bus.mem_we ? int'(bus.mem_addr) : int'(bus.tf_col);
                a.data = bus.mem_we ? int'(bus.mem_wdata) : int'(bus.tf_wdata);
                if (wq.size() == 0) begin
                    check("wr_unexpected", wq.size(), 1);
                end else begin
                    e = wq.pop_front();
                    vectors++;
                    if (a.kind != e.kind || a.i1 != e.i1 || a.i2 != e.i2 || a.data != e.data) begin
                        errors++;
                        $display("FAIL write: got kind %0d idx %0d/%0d data %0d, expected kind %0d idx %0d/%0d data %0d",
                                 a.kind, a.i1, a.i2, a.data, e.kind, e.i1, e.i2, e.data);
                    end
                end
            end
            if (stall_prev) begin
                check("stall_valid_held", bus.m_valid, 1);
                check("stall_data_held", bus.m_data, prev_data);
            end
            if (bus.m_valid && bus.m_ready) begin
                acc_cnt++;
                if (oq.size() == 0) begin
                    check("out_unexpected", oq.size(), 1);
                end else begin
                    exp_d = oq.pop_front();
                    check("out_data", bus.m_data, exp_d);
                end
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            stall_prev = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            if (bus.mem_re) begin
                issued++;
                check("read_after_done", done_given, 1);
                check("outstanding_le2", (issued - acc_cnt) <= 2, 1);
            end
            if (bus.ntt_start) starts++;
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.modulus   = DW'(65537);
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.ntt_done  = 1'b0;
        bus.m_ready   = 1'b0;
        #1 rst = 1'b0;
        #1 check_zero("reset");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        run_job(1'b0, -1, 5, 1'b0);
        run_job(1'b1, 100, 0, 1'b0);
        run_job(1'b1, -1, 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
